// File: rtl/spw_rx_packet_reader.sv
// -----------------------------------------------------------------------------
// spw_rx_packet_reader
//   Drains the SpaceWire CODEC receive FIFO one N-char at a time, assembles
//   each packet (up to its EOP/EEP marker) into a local byte buffer and holds
//   it for the CPU, which reads it through a registered random-access port and
//   releases it with pkt_ack.
//
// Ports
//   CLOCK       system clock (shared with the CODEC FIFO interface)
//   RESET       synchronous, active-high reset
//   enable      allows new FIFO reads from FETCH
//   rx_empty    CODEC receive FIFO empty flag
//   rx_data     CODEC FIFO output, valid the cycle after rx_rd; bit8 = control
//   rx_rd       FIFO read enable, single-cycle pulse
//   pkt_valid   a completed packet is held in the buffer
//   pkt_len     stored byte count (0 .. 2**ADDR_W), tracks assembly live
//   pkt_err     packet ended by EEP or an unknown control char
//   pkt_trunc   packet overflowed the buffer; excess bytes dropped
//   pkt_ack     CPU releases the buffer (only honoured while holding a packet)
//   rd_addr     buffer read address
//   rd_data     buffer byte at rd_addr, one cycle latency
//   good_count  saturating count of clean EOP-terminated packets
//   bad_count   saturating count of packets with pkt_err or pkt_trunc
// -----------------------------------------------------------------------------
module spw_rx_packet_reader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              enable,
  input  logic              rx_empty,
  input  logic [8:0]        rx_data,
  output logic              rx_rd,
  output logic              pkt_valid,
  output logic [ADDR_W:0]   pkt_len,
  output logic              pkt_err,
  output logic              pkt_trunc,
  input  logic              pkt_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [CNT_W-1:0]  good_count,
  output logic [CNT_W-1:0]  bad_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic               err_q;
  logic               trunc_q;
  logic               valid_q;
  logic [CNT_W-1:0]   good_q;
  logic [CNT_W-1:0]   bad_q;
  logic [7:0]         rd_data_q;
  logic [7:0]         buf_q [DEPTH];

  logic               len_full;
  logic               is_ctrl;
  logic               end_err;
  logic               wr_en;

  // Buffer is full once len reaches exactly DEPTH (only the MSB set).
  assign len_full = len_q[ADDR_W];
  assign is_ctrl  = rx_data[8];
  // Any control char other than EOP (0x100) closes the packet as an error.
  assign end_err  = (rx_data[7:0] != 8'h00);
  assign wr_en    = (state_q == ST_CAPTURE) && !is_ctrl && !len_full && !RESET;

  // The read strobe must be decided in the same cycle as rx_empty so the
  // FIFO is never read while empty; the FSM state itself is registered.
  assign rx_rd = (state_q == ST_FETCH) && enable && !rx_empty && !RESET;

  // Packet assembly FSM with registered status and statistics.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_FETCH;
      len_q   <= '0;
      err_q   <= 1'b0;
      trunc_q <= 1'b0;
      valid_q <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (enable && !rx_empty) begin
            state_q <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (!is_ctrl) begin
            if (!len_full) begin
              len_q <= len_q + LEN_W'(1);
            end else begin
              trunc_q <= 1'b1;
            end
            state_q <= ST_FETCH;
          end else begin
            err_q   <= end_err;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
            // Statistics update exactly once, on the transition into DONE.
            if (end_err || trunc_q) begin
              if (bad_q != {CNT_W{1'b1}}) begin
                bad_q <= bad_q + CNT_W'(1);
              end
            end else begin
              if (good_q != {CNT_W{1'b1}}) begin
                good_q <= good_q + CNT_W'(1);
              end
            end
          end
        end

        ST_DONE: begin
          if (pkt_ack) begin
            len_q   <= '0;
            err_q   <= 1'b0;
            trunc_q <= 1'b0;
            valid_q <= 1'b0;
            state_q <= ST_FETCH;
          end
        end

        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  // Packet buffer write port; contents survive reset.
  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      buf_q[len_q[ADDR_W-1:0]] <= rx_data[7:0];
    end
  end

  // Registered read port; a same-cycle write returns the old byte.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= buf_q[rd_addr];
    end
  end

  assign pkt_valid  = valid_q;
  assign pkt_len    = len_q;
  assign pkt_err    = err_q;
  assign pkt_trunc  = trunc_q;
  assign rd_data    = rd_data_q;
  assign good_count = good_q;
  assign bad_count  = bad_q;

endmodule

// File: tb/tb_spw_rx_packet_reader.sv
// -----------------------------------------------------------------------------
// tb_spw_rx_packet_reader
//   Directed and randomized packets fed through a queue-based FIFO model.
//   Expected length/flags/bytes/counters come from a packet-level reference.
// -----------------------------------------------------------------------------
module tb_spw_rx_packet_reader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CNT_W  = 16;
  localparam int          DEPTH  = 64;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic              enable;
  logic              rx_empty;
  logic [8:0]        rx_data;
  logic              rx_rd;
  logic              pkt_valid;
  logic [ADDR_W:0]   pkt_len;
  logic              pkt_err;
  logic              pkt_trunc;
  logic              pkt_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [CNT_W-1:0]  good_count;
  logic [CNT_W-1:0]  bad_count;

  spw_rx_packet_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .enable     (enable),
    .rx_empty   (rx_empty),
    .rx_data    (rx_data),
    .rx_rd      (rx_rd),
    .pkt_valid  (pkt_valid),
    .pkt_len    (pkt_len),
    .pkt_err    (pkt_err),
    .pkt_trunc  (pkt_trunc),
    .pkt_ack    (pkt_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .good_count (good_count),
    .bad_count  (bad_count)
  );

  always #5 CLOCK = ~CLOCK;

  int tests = 0;
  int fails = 0;

  // FIFO model and read bookkeeping
  logic [8:0] fifo [$];
  logic [8:0] pkt  [$];
  int         gaps [$];
  int         cyc_n = 0;
  int         rd_cnt = 0;
  int         last_rd = -100;
  bit         rd_pend = 1'b0;
  bit         tog_mode = 1'b0;
  bit         tog = 1'b0;
  bit         rand_en = 1'b0;

  // Packet-level reference
  logic [7:0] exp_bytes [$];
  bit         exp_err;
  bit         exp_trunc;
  int         exp_good = 0;
  int         exp_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    rx_empty = (fifo.size() == 0) || (tog_mode && tog);
  endtask

  // One clock: starts and ends at a negedge.
  task automatic cyc();
    #4;
    if (rx_rd) begin
      check("rd_guard", 32'({rx_empty, ~enable}), 32'd0);
      if (last_rd >= 0) gaps.push_back(cyc_n - last_rd);
      last_rd = cyc_n;
      rd_cnt++;
      rd_pend = 1'b1;
    end
    #2;
    cyc_n++;
    if (rd_pend) begin
      if (fifo.size() > 0) rx_data = fifo.pop_front();
      else rx_data = 9'h1FF;
      rd_pend = 1'b0;
    end
    if (rand_en) enable = 1'($urandom_range(0, 1));
    tog = ~tog;
    upd_empty();
    @(negedge CLOCK);
  endtask

  // Reference: stored bytes, truncation and error derived from the char list.
  task automatic model_pkt();
    exp_bytes.delete();
    exp_err = 1'b0;
    exp_trunc = 1'b0;
    foreach (pkt[i]) begin
      if (!pkt[i][8]) begin
        if (exp_bytes.size() < DEPTH) exp_bytes.push_back(pkt[i][7:0]);
        else exp_trunc = 1'b1;
      end else begin
        exp_err = (pkt[i][7:0] != 8'h00);
        break;
      end
    end
  endtask

  task automatic gen_pkt(input int ndata, input logic [8:0] term);
    pkt.delete();
    for (int i = 0; i < ndata; i++) pkt.push_back({1'b0, 8'($urandom)});
    pkt.push_back(term);
  endtask

  task automatic load_pkt();
    model_pkt();
    foreach (pkt[i]) fifo.push_back(pkt[i]);
    rd_cnt = 0;
    last_rd = -100;
    gaps.delete();
    upd_empty();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!pkt_valid && n < 3000) begin
      cyc();
      n++;
    end
    check(tag, 32'(pkt_valid), 32'd1);
  endtask

  task automatic verify_pkt(input string tag);
    if (exp_err || exp_trunc) exp_bad++;
    else exp_good++;
    check({tag, "_len"},   32'(pkt_len),   32'(exp_bytes.size()));
    check({tag, "_err"},   32'(pkt_err),   32'(exp_err));
    check({tag, "_trunc"}, 32'(pkt_trunc), 32'(exp_trunc));
    check({tag, "_rdcnt"}, 32'(rd_cnt),    32'(pkt.size()));
    check({tag, "_good"},  32'(good_count), 32'(exp_good));
    check({tag, "_bad"},   32'(bad_count),  32'(exp_bad));
    foreach (exp_bytes[i]) begin
      rd_addr = ADDR_W'(i);
      cyc();
      check({tag, "_byte"}, 32'(rd_data), 32'(exp_bytes[i]));
    end
  endtask

  task automatic ack_pkt(input string tag);
    pkt_ack = 1'b1;
    cyc();
    pkt_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(pkt_valid), 32'd0);
    check({tag, "_ack_len"},   32'(pkt_len),   32'd0);
    check({tag, "_ack_flags"}, 32'({pkt_err, pkt_trunc}), 32'd0);
  endtask

  initial begin
    logic [8:0] term;
    int         nd;

    RESET = 1'b1; enable = 1'b0; rx_empty = 1'b1; rx_data = 9'h000;
    pkt_ack = 1'b0; rd_addr = '0;
    @(negedge CLOCK);
    cyc(); cyc();
    check("rst_rx_rd",  32'(rx_rd), 32'd0);
    check("rst_status", 32'({pkt_valid, pkt_err, pkt_trunc}), 32'd0);
    check("rst_len",    32'(pkt_len), 32'd0);
    check("rst_rddata", 32'(rd_data), 32'd0);
    check("rst_counts", 32'({good_count, bad_count}), 32'd0);
    RESET = 1'b0;
    enable = 1'b1;
    cyc();

    // Basic two-byte packet, back-to-back reads two cycles apart
    pkt.delete();
    pkt.push_back(9'h0AA); pkt.push_back(9'h055); pkt.push_back(9'h100);
    load_pkt();
    wait_valid("t1_valid");
    check("t1_ngaps", 32'(gaps.size()), 32'd2);
    foreach (gaps[i]) check("t1_gap", 32'(gaps[i]), 32'd2);
    verify_pkt("t1");
    ack_pkt("t1");

    // Empty packet
    pkt.delete();
    pkt.push_back(9'h100);
    load_pkt();
    wait_valid("t2_valid");
    verify_pkt("t2");
    ack_pkt("t2");

    // Overflow: 70 bytes then EEP
    pkt.delete();
    for (int i = 0; i < 70; i++) pkt.push_back(9'(i));
    pkt.push_back(9'h101);
    load_pkt();
    wait_valid("t3_valid");
    rd_addr = 6'd63;
    cyc();
    check("t3_buf63", 32'(rd_data), 32'h3F);
    verify_pkt("t3");
    ack_pkt("t3");

    // Second packet queued while the first is held: no reads until ack
    gen_pkt(5, 9'h100);
    load_pkt();
    wait_valid("t4a_valid");
    verify_pkt("t4a");
    gen_pkt(7, 9'h1A5);
    load_pkt();
    for (int i = 0; i < 10; i++) cyc();
    check("t4_held_rd", 32'(rd_cnt), 32'd0);
    check("t4_held_valid", 32'(pkt_valid), 32'd1);
    ack_pkt("t4a");
    wait_valid("t4b_valid");
    verify_pkt("t4b");
    ack_pkt("t4b");

    // Reset in the middle of a packet
    fifo.push_back(9'h011); fifo.push_back(9'h022); fifo.push_back(9'h033);
    rd_cnt = 0;
    upd_empty();
    for (int i = 0; i < 10; i++) cyc();
    check("t5_partial_len", 32'(pkt_len), 32'd3);
    RESET = 1'b1;
    cyc();
    check("t5_rst_len",    32'(pkt_len), 32'd0);
    check("t5_rst_status", 32'({pkt_valid, pkt_err, pkt_trunc, rx_rd}), 32'd0);
    check("t5_rst_counts", 32'({good_count, bad_count}), 32'd0);
    check("t5_rst_rddata", 32'(rd_data), 32'd0);
    RESET = 1'b0;
    exp_good = 0;
    exp_bad = 0;
    gen_pkt(4, 9'h100);
    load_pkt();
    wait_valid("t5_valid");
    verify_pkt("t5");
    ack_pkt("t5");

    // Toggling empty flag and random enable drops
    tog_mode = 1'b1;
    rand_en = 1'b1;
    gen_pkt(20, 9'h100);
    load_pkt();
    wait_valid("t6_valid");
    verify_pkt("t6");
    ack_pkt("t6");

    // Randomized packets
    for (int p = 0; p < 12; p++) begin
      tog_mode = 1'($urandom_range(0, 1));
      rand_en  = 1'($urandom_range(0, 1));
      if (!rand_en) enable = 1'b1;
      nd = int'($urandom_range(0, 75));
      case ($urandom_range(0, 2))
        0:       term = 9'h100;
        1:       term = 9'h101;
        default: term = {1'b1, 8'($urandom_range(2, 255))};
      endcase
      gen_pkt(nd, term);
      load_pkt();
      wait_valid("rnd_valid");
      verify_pkt("rnd");
      ack_pkt("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spw_rx_packet_reader.md
Name: spw_rx_packet_reader

Overview:
- Hardware drain engine for the SpaceWire CODEC receive FIFO.
- Issues read-enable pulses to the FIFO and captures 9-bit N-chars.
- Assembles each packet, up to its EOP/EEP marker, into a local byte buffer.
- Presents the completed packet to the NIOS side as a length, status flags and a random-access read port, released by an acknowledge.
- Replaces software polling of the receive FIFO through PIO plus edge detection.

Parameters:
- ADDR_W, 6, buffer address width; buffer depth = 2**ADDR_W bytes.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- CLOCK  in  1  system clock (NIOS clock domain, same clock as the CODEC FIFO interface)
- RESET  in  1  synchronous, active-high reset
- enable  in  1  allows new FIFO reads when high
- rx_empty  in  1  CODEC receiveFIFOEmpty
- rx_data  in  9  CODEC receiveFIFODataOut; bit8=1 marks a control char; 0x00 = EOP, 0x01 = EEP
- rx_rd  out  1  CODEC receiveFIFOReadEnable, single-cycle pulse
- pkt_valid  out  1  completed packet held in buffer
- pkt_len  out  ADDR_W+1  stored byte count, 0..2**ADDR_W
- pkt_err  out  1  packet ended by EEP or by an unknown control char
- pkt_trunc  out  1  packet exceeded buffer; excess bytes dropped
- pkt_ack  in  1  CPU releases the buffer
- rd_addr  in  ADDR_W  buffer read address
- rd_data  out  8  buffer byte, registered
- good_count  out  CNT_W  packets ended by EOP without truncation, saturating
- bad_count  out  CNT_W  packets with pkt_err or pkt_trunc, saturating

Behaviour:
- Clocking and reset: one clock (CLOCK); RESET is synchronous, active-high.
- RESET effect:
  - state=FETCH.
  - rx_rd=0, pkt_valid=0, pkt_len=0, pkt_err=0, pkt_trunc=0, rd_data=0, good_count=0, bad_count=0.
  - Buffer RAM is not cleared.
  - Any partial packet is discarded and not counted.
- FIFO protocol: rx_data is valid in the cycle after the rx_rd pulse. rx_rd is never asserted while rx_empty=1 or while a prior read is outstanding.
- FSM states: FETCH, CAPTURE, DONE.
- FETCH:
  - If enable=1 and rx_empty=0: rx_rd=1 for this cycle, next state CAPTURE.
  - Otherwise stay in FETCH with rx_rd=0.
- CAPTURE (sample rx_data):
  - Data char (bit8=0):
    - If len < 2**ADDR_W: write buf[len]=rx_data[7:0], len=len+1.
    - Else: drop the byte, pkt_trunc=1.
    - Next state FETCH.
  - rx_data=0x100 (EOP): next state DONE, pkt_err=0.
  - rx_data=0x101 (EEP): next state DONE, pkt_err=1.
  - Other control char (bit8=1, byte > 0x01): treated as EEP, pkt_err=1, next state DONE.
- Throughput: one char per 2 cycles.
- DONE:
  - pkt_valid=1; pkt_len, pkt_err and pkt_trunc are stable; rx_rd=0.
  - good_count or bad_count increments exactly once, on entry to DONE; both saturate at all-ones.
  - On pkt_ack=1: next cycle len=0, pkt_err=0, pkt_trunc=0, pkt_valid=0, state FETCH.
- pkt_len tracking: pkt_len mirrors the internal len at all times and saturates at 2**ADDR_W.
- Empty packet: EOP as the first char gives pkt_valid with pkt_len=0.
- pkt_ack outside DONE is ignored. pkt_ack held high across DONE entry releases the buffer one cycle after entry, so pkt_valid is high for one cycle.
- Deasserting enable only blocks new reads from FETCH. A CAPTURE already in flight completes, and a packet may be left partially assembled until enable returns.
- Read port:
  - rd_data = buf[rd_addr], registered with 1-cycle latency, in any state.
  - Addresses >= pkt_len return stale data.
  - A write to the addressed location in the same cycle as the read returns the old byte.

Test Plan:
- FIFO preloaded with 0x0AA, 0x055, 0x100 and enable=1 -> exactly 3 rx_rd pulses, 2 cycles apart; pkt_valid=1 with pkt_len=2, pkt_err=0; rd_addr 0,1 -> rd_data 0xAA, 0x55 one cycle later; good_count=1.
- FIFO holds only 0x100 -> pkt_valid, pkt_len=0, good_count=1; then pkt_ack -> pkt_valid=0 next cycle, FSM returns to FETCH.
- 70 data bytes 0x00..0x45 then 0x101, with ADDR_W=6 -> pkt_len=64, pkt_trunc=1, pkt_err=1; buf[63]=0x3F; bad_count=1; only 71 rx_rd pulses.
- Second packet arrives while DONE is held and no ack is given -> no rx_rd pulses; after pkt_ack, the second packet is read and its bytes land from address 0.
- RESET asserted mid-packet after 3 bytes -> all outputs zero next cycle; the next packet starts at len=0; counters zero.
- rx_empty toggling every cycle, plus enable dropped during CAPTURE -> rx_rd never high while rx_empty=1; the in-flight byte is stored; no reads occur while enable=0.
